// File: rtl/mode_sequencer.sv
// Front-panel mode controller: debounced button steps display sources.
// Optional auto-return to mode 0 after idle: define MODE_SEQ_AUTO_RETURN_EN.
module mode_sequencer #(
    parameter int NUM_MODES    = 3,
    parameter int DEBOUNCE_CYC = 20,
    parameter int BLANK_CYC    = 10,
    parameter int IDLE_TIMEOUT = 30000,
    localparam int MODE_W      = $clog2(NUM_MODES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode_btn,
    input  logic [NUM_MODES*8-1:0] seg_dat_in,
    input  logic [NUM_MODES*8-1:0] seg_com_in,
    output logic [7:0]             seg_dat,
    output logic [7:0]             seg_com,
    output logic [MODE_W-1:0]      mode_idx,
    output logic [NUM_MODES-1:0]   mode_onehot,
    output logic                   mode_change
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int BL_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

    logic              btn_s1;
    logic              btn_s2;
    logic              btn_db;
    logic              btn_db_q;
    logic [DB_W-1:0]   db_cnt;
    logic [BL_W-1:0]   blank_cnt;
    logic              press;
    logic              timeout;
    logic [MODE_W-1:0] mode_nxt;
    logic              change_nxt;
    logic [7:0]        chan_dat;
    logic [7:0]        chan_com;

    // Two-flop synchroniser for the raw button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= mode_btn;
            btn_s2 <= btn_s1;
        end
    end

    // Debounce: level follows only after DEBOUNCE_CYC stable mismatches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                btn_db <= btn_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

`ifdef MODE_SEQ_AUTO_RETURN_EN
    localparam int ID_W = $clog2(IDLE_TIMEOUT + 1);

    logic [ID_W-1:0] idle_cnt;

    assign timeout = (mode_idx != '0) &&
                     (idle_cnt == ID_W'(IDLE_TIMEOUT - 1));

    // Idle counter: runs only while away from mode 0 with no presses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (press || mode_idx == '0 || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_idle;

    assign timeout     = 1'b0;
    assign unused_idle = |IDLE_TIMEOUT;
`endif

    // Next mode: a press advances (and beats a same-cycle timeout)
    always_comb begin
        mode_nxt   = mode_idx;
        change_nxt = 1'b0;
        if (press) begin
            mode_nxt   = (mode_idx == LAST_MODE) ? '0 : mode_idx + 1'b1;
            change_nxt = 1'b1;
        end else if (timeout) begin
            mode_nxt   = '0;
            change_nxt = 1'b1;
        end
    end

    // Mode register and change pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_idx    <= '0;
            mode_change <= 1'b0;
        end else begin
            mode_idx    <= mode_nxt;
            mode_change <= change_nxt;
        end
    end

    // Blank counter: reloads on every mode change, then counts down
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_cnt <= '0;
        end else if (change_nxt) begin
            blank_cnt <= BL_W'(BLANK_CYC);
        end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 1'b1;
        end
    end

    // Channel select and one-hot decode of the current mode
    always_comb begin
        chan_dat    = 8'h00;
        chan_com    = 8'hFF;
        mode_onehot = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (mode_idx == MODE_W'(k)) begin
                chan_dat       = seg_dat_in[8*k +: 8];
                chan_com       = seg_com_in[8*k +: 8];
                mode_onehot[k] = 1'b1;
            end
        end
    end

    // Registered display bus, forced off while blanking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_dat <= 8'h00;
            seg_com <= 8'hFF;
        end else if (blank_cnt != '0) begin
            seg_dat <= 8'h00;
            seg_com <= 8'hFF;
        end else begin
            seg_dat <= chan_dat;
            seg_com <= chan_com;
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed sections plus random button runs,
// each cycle compared against a window/timestamp reference model.
module tb_mode_sequencer;

    localparam int NM = 3;
    localparam int DB = 4;
    localparam int BC = 2;
    localparam int IT = 20;
`ifdef MODE_SEQ_AUTO_RETURN_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          mode_btn;
    logic [NM*8-1:0] seg_dat_in;
    logic [NM*8-1:0] seg_com_in;
    logic [7:0]    seg_dat;
    logic [7:0]    seg_com;
    logic [1:0]    mode_idx;
    logic [NM-1:0] mode_onehot;
    logic          mode_change;

    int total = 0;
    int bad   = 0;
    int ec    = 0;
    int gec   = 0;
    int mc_cnt = 0;

    bit   smp[$];
    bit   m_deb;
    bit   m_debp;
    int   m_mode;
    bit   m_mc;
    logic [7:0] m_dat;
    logic [7:0] m_com;
    int   m_last;
    int   m_idle;

    mode_sequencer #(
        .NUM_MODES(NM),
        .DEBOUNCE_CYC(DB),
        .BLANK_CYC(BC),
        .IDLE_TIMEOUT(IT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode_btn(mode_btn),
        .seg_dat_in(seg_dat_in),
        .seg_com_in(seg_com_in),
        .seg_dat(seg_dat),
        .seg_com(seg_com),
        .mode_idx(mode_idx),
        .mode_onehot(mode_onehot),
        .mode_change(mode_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        smp.delete();
        repeat (DB + 2) smp.push_back(1'b0);
        m_deb  = 1'b0;
        m_debp = 1'b0;
        m_mode = 0;
        m_mc   = 1'b0;
        m_dat  = 8'h00;
        m_com  = 8'hFF;
        m_last = -1000;
        m_idle = 0;
    endtask

    // Button accepted once the last DB delayed samples all disagree
    // with the debounced level; blanking is BC edges after a change.
    task automatic model_edge();
        bit press;
        bit flip;
        bit tmo;
        int nm;
        press = m_deb && !m_debp;
        flip = 1'b1;
        for (int k = 1; k <= DB; k++)
            if (smp[k] == m_deb) flip = 1'b0;
        tmo = 1'b0;
        if (AR) begin
            if (press || m_mode == 0) m_idle = 0;
            else if (m_idle + 1 == IT) begin
                tmo = 1'b1;
                m_idle = 0;
            end else m_idle++;
        end
        if (gec - m_last >= 1 && gec - m_last <= BC) begin
            m_dat = 8'h00;
            m_com = 8'hFF;
        end else begin
            m_dat = seg_dat_in[8*m_mode +: 8];
            m_com = seg_com_in[8*m_mode +: 8];
        end
        nm = press ? (m_mode + 1) % NM : (tmo ? 0 : m_mode);
        m_mc = press || tmo;
        if (m_mc) m_last = gec;
        m_debp = m_deb;
        if (flip) m_deb = !m_deb;
        m_mode = nm;
        smp.push_front(mode_btn);
        void'(smp.pop_back());
    endtask

    task automatic check_all();
        chk("mode_idx", 32'(mode_idx), 32'(m_mode));
        chk("mode_onehot", 32'(mode_onehot), 32'(1) << m_mode);
        chk("mode_change", 32'(mode_change), 32'(m_mc));
        chk("seg_dat", 32'(seg_dat), 32'(m_dat));
        chk("seg_com", 32'(seg_com), 32'(m_com));
    endtask

    task automatic step(input logic b, input logic [23:0] d,
                        input logic [23:0] c);
        @(negedge clk);
        mode_btn   = b;
        seg_dat_in = d;
        seg_com_in = c;
        @(posedge clk);
        gec++;
        if (rst) begin
            ec++;
            model_edge();
        end
        #1;
        check_all();
        if (mode_change) mc_cnt++;
    endtask

    task automatic stepr(input logic b);
        step(b, 24'($urandom), 24'($urandom));
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        stepr(1'b0);
        stepr(1'b0);
        rst = 1'b1;
        ec = 0;
        mc_cnt = 0;
    endtask

    initial begin
        int m0;
        rst        = 1'b1;
        mode_btn   = 1'b0;
        seg_dat_in = '0;
        seg_com_in = '1;
        model_reset();

        // reset, then channel 0 appears one cycle after release
        do_reset();
        step(1'b0, 24'h3C5AA5, 24'hFDFBFE);
        chk("rel_dat", 32'(seg_dat), 32'hA5);
        chk("rel_com", 32'(seg_com), 32'hFE);

        // bounce: short pulses never accepted
        for (int i = 0; i < 5; i++) stepr(1'b0);
        m0 = mode_idx;
        mc_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(1, 3)) stepr(1'b1);
            repeat ($urandom_range(1, 4)) stepr(1'b0);
        end
        chk("bounce_mode", 32'(mode_idx), 32'(m0));
        chk("bounce_pulses", 32'(mc_cnt), 32'd0);

        // clean press held long: one change at edge 7
        do_reset();
        for (int i = 0; i < 60; i++) begin
            stepr(1'b1);
            chk("press_mc", 32'(mode_change),
                32'((ec == 7) || (AR && ec == 7 + IT)));
            if (ec == 7) chk("press_mode", 32'(mode_idx), 32'd1);
            if (ec == 8 || ec == 9) begin
                chk("blank_dat", 32'(seg_dat), 32'h00);
                chk("blank_com", 32'(seg_com), 32'hFF);
            end
        end
        chk("press_pulses", 32'(mc_cnt), AR ? 32'd2 : 32'd1);

        // wrap through all modes
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            repeat (8) stepr(1'b1);
            repeat (8) stepr(1'b0);
            chk("wrap_mode", 32'(mode_idx), 32'(k % NM));
            chk("wrap_onehot", 32'(mode_onehot), 32'(1) << (k % NM));
        end
        chk("wrap_pulses", 32'(mc_cnt), 32'd3);

        // idle hold / auto-return
        do_reset();
        repeat (8) stepr(1'b1);
        for (int i = 0; i < 1000; i++) begin
            stepr(1'b0);
            if (ec == 7 + IT)
                chk("ar_mc", 32'(mode_change), 32'(AR));
        end
        chk("hold_mode", 32'(mode_idx), AR ? 32'd0 : 32'd1);
        chk("hold_pulses", 32'(mc_cnt), AR ? 32'd2 : 32'd1);

        // press accepted in the timeout cycle wins
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            stepr((i <= 10 || i > 20) ? 1'b1 : 1'b0);
            if (ec == 7 + IT) begin
                chk("coll_mode", 32'(mode_idx), 32'd2);
                chk("coll_mc", 32'(mode_change), 32'd1);
            end
        end
        for (int i = 0; i < 30; i++) stepr(1'b0);

        // random button runs with a reset mid-run
        do_reset();
        for (int r = 0; r < 80; r++) begin
            logic lv;
            lv = 1'($urandom);
            repeat ($urandom_range(1, 10)) stepr(lv);
            if (r == 40) begin
                stepr(1'b1);
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Generalised mode controller for the front-panel board.
- Debounces a raw mode push-button and steps through NUM_MODES display sources, wrapping back to mode 0.
- Drives the shared 8-digit 7-segment bus from a registered mux of per-mode channels.
- Blanks the display briefly on every mode change and exports the current mode to other blocks (LED and LCD control).

Parameters:
- NUM_MODES, 3: number of display sources/modes, minimum 2; MODE_W = $clog2(NUM_MODES) is a derived localparam.
- DEBOUNCE_CYC, 20: consecutive stable clk cycles required before the debounced button level changes; minimum 1.
- BLANK_CYC, 10: cycles the display is forced off after a mode change; 0 disables blanking.
- IDLE_TIMEOUT, 30000: cycles without an accepted press before auto-return to mode 0 (used only with AUTO_RETURN_EN).

Ports:
- clk, input, 1: system clock (1 kHz board clock).
- rst, input, 1: asynchronous, active-low reset.
- mode_btn, input, 1: raw, asynchronous mode push-button, active-high.
- seg_dat_in, input, NUM_MODES*8: packed segment data; channel k occupies bits [8k+7:8k].
- seg_com_in, input, NUM_MODES*8: packed digit commons, same packing, active-low.
- seg_dat, output, 8: registered segment data to the display.
- seg_com, output, 8: registered digit commons to the display.
- mode_idx, output, MODE_W: current mode.
- mode_onehot, output, NUM_MODES: one-hot decode of mode_idx.
- mode_change, output, 1: one-cycle pulse in the cycle mode_idx takes a new value.

Behaviour:
- Reset (rst low, asynchronous), all registers cleared:
  - mode_idx=0, mode_onehot=1, mode_change=0.
  - seg_dat=8'h00, seg_com=8'hFF.
  - Synchroniser flops, debounced level, debounce counter, blank counter and idle counter all 0.
- Synchroniser: two flops on mode_btn.
- Debounce:
  - Counter increments each cycle the synchronised level differs from the debounced level; it clears on any match.
  - When the count reaches DEBOUNCE_CYC, the debounced level takes the synchronised value and the counter clears.
- Press detect: a press is accepted on a debounced rising edge (debounced=1 while previous=0).
  - Exactly one press per physical press, however long it is held.
  - A release never advances the mode.
- Mode register:
  - On an accepted press, mode_idx <= (mode_idx==NUM_MODES-1) ? 0 : mode_idx+1, and mode_change pulses in the same cycle.
  - Total latency: mode_idx changes at the (DEBOUNCE_CYC+3)th rising clk edge after mode_btn goes high and stays stable.
  - Glitches shorter than DEBOUNCE_CYC cycles after synchronisation are ignored.
- Blanking:
  - In the cycle mode_change is high, the blank counter loads BLANK_CYC.
  - While the counter is nonzero: it decrements each cycle, seg_dat=8'h00, seg_com=8'hFF.
  - A new mode change during blanking reloads the counter.
- Output mux:
  - When not blanking, seg_dat/seg_com <= channel[mode_idx] of seg_dat_in/seg_com_in; one-cycle registered latency from mode_idx and the inputs.
  - With BLANK_CYC=0, the new channel appears one cycle after mode_idx changes.
- Reset mid-operation (including mid-debounce or mid-blank) immediately restores all reset values; no pending press survives.

Optional Feature:
- Macro: MODE_SEQ_AUTO_RETURN_EN.
- Defined:
  - Idle counter clears on every accepted press and whenever mode_idx==0; otherwise it increments.
  - On reaching IDLE_TIMEOUT: mode_idx <= 0, mode_change pulses, blanking starts, counter clears.
  - If a press is accepted in the same cycle as the timeout, the press wins: mode advances from its current value and the counter clears.
- Undefined: no idle counter; mode_idx changes only on accepted presses.

Test Plan (NUM_MODES=3, DEBOUNCE_CYC=4, BLANK_CYC=2, IDLE_TIMEOUT=20):
- Reset: hold rst=0 mid-run -> seg_dat=00, seg_com=FF, mode_idx=0, mode_onehot=001 immediately; rst=1 with channel0={dat A5, com FE} -> seg_dat=A5, seg_com=FE one cycle later.
- Press: mode_btn held high from cycle 0 -> mode_idx=1 and mode_change=1 at edge 7 only; seg outputs FF/00 for 2 cycles, then channel1 values; holding 50 more cycles gives no further change.
- Bounce: mode_btn pulses of 1-3 cycles separated by low gaps -> mode_idx unchanged, mode_change never asserted.
- Wrap: three clean presses -> mode_idx 1, 2, 0; mode_onehot 010, 100, 001; exactly three mode_change pulses.
- Auto-return (macro defined): one press to mode 1, then idle -> mode_idx=0 with mode_change pulse 20 cycles after the press; with macro undefined, mode_idx stays at 1 for 1000 cycles.
- Collision (macro defined): press accepted in the exact timeout cycle while in mode 1 -> mode_idx=2, not 0; idle counter restarts.
